sync_fifo_flex: RTL and testbench
=================================

# sync_fifo_flex

Parametrised single-clock FIFO that succeeds the fixed power-of-two FIFO in the datapath buffering layer. It supports any depth ≥ 2, including non-power-of-two. It adds an occupancy count, programmable almost-full and almost-empty flags, a synchronous flush, and sticky overflow/underflow error flags. First-word-fall-through read mode is available at compile time.

## Interface
- DATA_WIDTH, 8: word width in bits.
- DEPTH, 16: number of entries, any integer ≥ 2.
- AF_THRESH, DEPTH-2: almost_full asserts when count ≥ AF_THRESH. Legal range 1..DEPTH.
- AE_THRESH, 2: almost_empty asserts when count ≤ AE_THRESH. Legal range 0..DEPTH-1.
- CNT_WIDTH, $clog2(DEPTH+1): width of count. Derived; do not override.

Ports:
- clk  in  1  sole clock; all state changes on the rising edge.
- rstn  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous flush, active high.
- wr_en  in  1  write request.
- din  in  DATA_WIDTH  write data.
- rd_en  in  1  read request.
- dout  out  DATA_WIDTH  read data.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count ≥ AF_THRESH.
- almost_empty  out  1  count ≤ AE_THRESH.
- count  out  CNT_WIDTH  current occupancy.
- overflow  out  1  sticky flag: a write was refused.
- underflow  out  1  sticky flag: a read was refused.

## Operation
- Pointers are indices 0..DEPTH-1 and wrap explicitly from DEPTH-1 to 0. There is no extra pointer bit.
- count is a register. full and empty are decoded from count.
- Read acceptance: rd_acc = rd_en & !empty.
- Write acceptance: wr_acc = wr_en & (!full | rd_acc).
  - A write to a full FIFO is accepted if it coincides with an accepted read.
- Count update: count += wr_acc - rd_acc. A simultaneous accepted write and read leave count unchanged.
- Simultaneous write and read on an empty FIFO: the write is accepted, the read is refused, and underflow is set.
- overflow is set on wr_en & !wr_acc. underflow is set on rd_en & !rd_acc.
  - Both flags hold until rstn or clr.
- almost_full and almost_empty are combinational from the count register.
- clr:
  - Zeroes both pointers, count, overflow, underflow and dout.
  - Overrides wr_en and rd_en in the same cycle; no flags are set.
  - Memory contents are not cleared.
- Reset values on rstn low: count 0, empty 1, full 0, almost_empty 1, almost_full 0, overflow 0, underflow 0, dout 0, both pointers 0.
- Reset mid-operation takes effect immediately (asynchronous) and discards all queued data.

## Timing
- Standard mode, macro absent:
  - dout is registered and loads the head word on the edge where rd_acc is true. Data is valid from the cycle after the read.
  - dout holds its value when no read is accepted.
- Write-to-readable latency: a word written at edge N makes empty=0 after edge N. rd_en may be asserted in the next cycle.
- count, full, empty, almost_full, almost_empty, overflow and underflow all update on the same edge as the accepted operation.

## Configuration
- Macro: SYNC_FIFO_FWFT_EN.
- Without the macro: standard registered-read behaviour as described under Timing.
- With the macro:
  - dout = mem[rd_ptr] combinationally while !empty, and '0 while empty.
  - The head word is visible in the cycle after it is written. rd_en acts as an acknowledge that pops the head on the edge.
  - dout has no reset register; its value after reset is 0 because empty is 1.
- All flags, count and acceptance rules are identical in both modes.

## Structure
- Package sync_fifo_pkg holds:
  - the function next_idx(idx, depth), which performs the wrapping increment;
  - the localparam helper for CNT_WIDTH.
- Sub-module sync_fifo_mem holds the storage:
  - DEPTH × DATA_WIDTH array;
  - one synchronous write port and one asynchronous read port;
  - no reset.
- sync_fifo_flex holds pointers, count, flags and the output stage.

## Test plan
- DEPTH=5, standard mode, write 0x11..0x15 -> full=1 and count=5 after the fifth edge. Five reads -> dout sequence 0x11..0x15, each one cycle after its rd_en, and empty=1.
- DEPTH=5, full FIFO, wr_en=1 (0xAA) and rd_en=1 in the same cycle -> count stays 5 and overflow=0. 0xAA emerges after four more reads, proving wrap 4->0.
- Empty FIFO, rd_en=1 -> underflow=1, count=0, dout unchanged. Write one word -> underflow stays 1. Pulse clr -> underflow=0.
- DEPTH=16, AF_THRESH=14, AE_THRESH=2:
  - fill to 2 -> almost_empty=1;
  - fill to 3 -> almost_empty=0;
  - fill to 14 -> almost_full=1;
  - fill to 16 then one extra write -> overflow=1, count=16.
- Load 3 words, assert clr together with wr_en and rd_en -> count=0, empty=1, dout=0, no flags set. Then deassert rstn mid-burst -> all outputs return to their reset values immediately.
- SYNC_FIFO_FWFT_EN defined, write 0x5A at edge N -> dout=0x5A and empty=0 in the cycle after N without rd_en. Assert rd_en -> empty=1 and dout=0 after the following edge.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared helpers for the flexible-depth synchronous FIFO.
package sync_fifo_pkg;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Wrapping increment for pointers that run 0..depth-1 with no extra bit.
  function automatic int unsigned next_idx(input int unsigned idx, input int unsigned depth);
    return (idx >= depth - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Storage array for sync_fifo_flex: one synchronous write port, one asynchronous read port, no reset.
module sync_fifo_mem #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [$clog2(DEPTH)-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0]     raddr,
  output logic [DATA_WIDTH-1:0]        rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO of any depth >= 2 with count, threshold flags, flush and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is a registered dout.
module sync_fifo_flex
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned AF_THRESH  = DEPTH - 2,
  parameter int unsigned AE_THRESH  = 2,
  parameter int unsigned CNT_WIDTH  = cnt_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_acc_c;
  logic                  wr_acc_c;
  logic                  mem_we_c;

  // Status is decoded from the count register only.
  assign empty        = (count == '0);
  assign full         = (count == CNT_WIDTH'(DEPTH));
  assign almost_full  = (count >= CNT_WIDTH'(AF_THRESH));
  assign almost_empty = (count <= CNT_WIDTH'(AE_THRESH));

  // A write into a full FIFO still lands when a read frees the head slot on the same edge.
  assign rd_acc_c = rd_en & ~empty;
  assign wr_acc_c = wr_en & (~full | rd_acc_c);
  assign mem_we_c = wr_acc_c & ~clr;

  sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we_c),
    .waddr (wr_ptr),
    .wdata (din),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc_c) wr_ptr <= PTR_W'(next_idx(32'(wr_ptr), DEPTH));
      if (rd_acc_c) rd_ptr <= PTR_W'(next_idx(32'(rd_ptr), DEPTH));
      if (wr_acc_c && !rd_acc_c)      count <= count + CNT_WIDTH'(1);
      else if (!wr_acc_c && rd_acc_c) count <= count - CNT_WIDTH'(1);
      if (wr_en && !wr_acc_c) overflow  <= 1'b1;
      if (rd_en && !rd_acc_c) underflow <= 1'b1;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is presented directly; rd_en only acknowledges it.
  assign dout = empty ? '0 : rd_data;
`else
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)         dout <= '0;
    else if (clr)      dout <= '0;
    else if (rd_acc_c) dout <= rd_data;
  end
`endif

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Scoreboard bench for sync_fifo_flex: a queue-based reference model predicts each cycle, a monitor compares.
module tb_sync_fifo_flex;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 5;
  localparam int unsigned AF    = 4;
  localparam int unsigned AE    = 1;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic          clk   = 1'b0;
  logic          rstn  = 1'b1;
  logic          clr   = 1'b0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] din   = '0;
  logic [DW-1:0] dout;
  logic          full, empty, almost_full, almost_empty, overflow, underflow;
  logic [CW-1:0] count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int cnt;
    bit full;
    bit empty;
    bit af;
    bit ae;
    bit ovf;
    bit udf;
    int dout;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] mq[$];
  logic [DW-1:0] dout_m = '0;
  bit            ovf_m  = 1'b0;
  bit            udf_m  = 1'b0;

  sync_fifo_flex #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .AF_THRESH  (AF),
    .AE_THRESH  (AE)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .clr          (clr),
    .wr_en        (wr_en),
    .din          (din),
    .rd_en        (rd_en),
    .dout         (dout),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t snapshot();
    exp_t e;
    e.cnt   = mq.size();
    e.full  = (mq.size() == DEPTH);
    e.empty = (mq.size() == 0);
    e.af    = (mq.size() >= AF);
    e.ae    = (mq.size() <= AE);
    e.ovf   = ovf_m;
    e.udf   = udf_m;
`ifdef SYNC_FIFO_FWFT_EN
    e.dout  = (mq.size() == 0) ? 0 : int'(mq[0]);
`else
    e.dout  = int'(dout_m);
`endif
    return e;
  endfunction

  function automatic void model_reset();
    mq.delete();
    ovf_m  = 1'b0;
    udf_m  = 1'b0;
    dout_m = '0;
  endfunction

  // Reference behaviour: the FIFO is just a bounded queue of words.
  function automatic void model_apply(input bit w, input logic [DW-1:0] d, input bit r, input bit c);
    bit rd_ok, wr_ok;
    if (c) begin
      model_reset();
      return;
    end
    rd_ok = r && (mq.size() > 0);
    wr_ok = w && ((mq.size() < DEPTH) || rd_ok);
    if (rd_ok) dout_m = mq.pop_front();
    if (wr_ok) mq.push_back(d);
    if (w && !wr_ok) ovf_m = 1'b1;
    if (r && !rd_ok) udf_m = 1'b1;
  endfunction

  task automatic step(input bit w, input logic [DW-1:0] d, input bit r, input bit c);
    exp_t e;
    @(negedge clk);
    wr_en = w;
    din   = d;
    rd_en = r;
    clr   = c;
    model_apply(w, d, r, c);
    e = snapshot();
    @(posedge clk);
    #1;
    exp_q.push_back(e);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_count"}, 32'(count), 0);
    chk({tag, "_empty"}, 32'(empty), 1);
    chk({tag, "_full"}, 32'(full), 0);
    chk({tag, "_ae"}, 32'(almost_empty), 1);
    chk({tag, "_af"}, 32'(almost_full), 0);
    chk({tag, "_ovf"}, 32'(overflow), 0);
    chk({tag, "_udf"}, 32'(underflow), 0);
    chk({tag, "_dout"}, 32'(dout), 0);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("count", 32'(count), 32'(e.cnt));
      chk("full", 32'(full), 32'(e.full));
      chk("empty", 32'(empty), 32'(e.empty));
      chk("almost_full", 32'(almost_full), 32'(e.af));
      chk("almost_empty", 32'(almost_empty), 32'(e.ae));
      chk("overflow", 32'(overflow), 32'(e.ovf));
      chk("underflow", 32'(underflow), 32'(e.udf));
      chk("dout", 32'(dout), 32'(e.dout));
    end
  end

  initial begin
    int pw, pr;
    #1 rstn = 1'b0;
    #2 check_reset_vals("por");
    model_reset();
    @(negedge clk);
    rstn = 1'b1;

    // Fill to full, then drain in order.
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h11 + i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);

    // Write+read on a full FIFO, then drain past the pointer wrap.
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h21 + i), 1'b0, 1'b0);
    step(1'b1, 8'hAA, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b0);

    // Underflow is sticky until flush.
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 8'h33, 1'b0, 1'b0);
    step(1'b1, 8'h34, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 8'h44, 1'b1, 1'b0);

    // Overflow on an extra write into a full FIFO.
    for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);

    // Flush overrides a simultaneous write and read.
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 8'h77, 1'b1, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a burst.
    for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    @(negedge clk);
    wr_en = 1'b1;
    din   = 8'hEE;
    rd_en = 1'b1;
    #2 rstn = 1'b0;
    #1 check_reset_vals("async_rst");
    model_reset();
    wr_en = 1'b0;
    rd_en = 1'b0;
    @(negedge clk);
    rstn = 1'b1;

    // Randomised traffic with phases biased toward filling or draining.
    pw = 50;
    pr = 50;
    for (int i = 0; i < 400; i++) begin
      if (i % 40 == 0) begin
        pw = $urandom_range(20, 90);
        pr = $urandom_range(20, 90);
      end
      step($urandom_range(0, 99) < pw, 8'($urandom), $urandom_range(0, 99) < pr,
           $urandom_range(0, 63) == 0);
    end

    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("drain", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
